// File: rtl/mic1_exec_ctrl.sv
// mic1_exec_ctrl: run/step/halt execution controller for the MIC-1 datapath.
// It turns front-panel start/stop and step pulses into the microinstruction
// enable, counts retired microinstructions and drives the rotating run LEDs.
// Optional feature macro: MIC1_EXEC_CYCLE_COUNT_EN builds the retire counter.
// When the macro is undefined, cycle_count is tied to zero.
module mic1_exec_ctrl #(
  parameter int CNT_W     = 16,
  parameter int LED_DIV_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_stop_evt,
  input  logic             step_evt,
  input  logic             cyc_done,
  input  logic             halt_req,
  output logic             cpu_en,
  output logic             running,
  output logic             halted,
  output logic [3:0]       led_run,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    STEP   = 3'd2,
    DRAIN  = 3'd3,
    HALTED = 3'd4
  } state_t;

  state_t               state, state_next;
  logic                 retire;
  logic [LED_DIV_W-1:0] prescaler;

  // A microinstruction retires only while we are actually requesting one.
  assign retire = cpu_en & cyc_done;

  // Next-state decision; a HALT retire always wins over any coincident event.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_stop_evt)  state_next = RUN;
        else if (step_evt)   state_next = STEP;
      end
      RUN: begin
        if (retire && halt_req)    state_next = HALTED;
        else if (start_stop_evt)   state_next = retire ? IDLE : DRAIN;
      end
      DRAIN, STEP: begin
        if (retire)                state_next = halt_req ? HALTED : IDLE;
      end
      HALTED: begin
        if (start_stop_evt)        state_next = IDLE;
      end
      default:                     state_next = IDLE;
    endcase
  end

  // State register plus outputs decoded from the next state, so all are registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cpu_en  <= 1'b0;
      running <= 1'b0;
      halted  <= 1'b0;
    end else begin
      state   <= state_next;
      cpu_en  <= (state_next == RUN) || (state_next == STEP) || (state_next == DRAIN);
      running <= (state_next == RUN) || (state_next == DRAIN);
      halted  <= (state_next == HALTED);
    end
  end

  // Run LEDs: rotate once per full prescaler wrap, all-on while halted, restart on leaving halt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_run   <= 4'b0001;
      prescaler <= '0;
    end else if (state == HALTED) begin
      if (state_next == IDLE) begin
        led_run   <= 4'b0001;
        prescaler <= '0;
      end
    end else if (state_next == HALTED) begin
      led_run <= 4'b1111;
    end else if (retire) begin
      prescaler <= prescaler + 1'b1;
      if (&prescaler) led_run <= {led_run[2:0], led_run[3]};
    end
  end

`ifdef MIC1_EXEC_CYCLE_COUNT_EN
  // Retired-microinstruction counter; wraps naturally and is cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       cycle_count <= '0;
    else if (retire) cycle_count <= cycle_count + 1'b1;
  end
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_mic1_exec_ctrl.sv
// Directed bench for mic1_exec_ctrl. A second instance with a 4-bit counter
// shares the same stimulus so counter wrap-around can be observed.
module tb_mic1_exec_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_stop_evt = 1'b0;
  logic        step_evt = 1'b0;
  logic        cyc_done = 1'b0;
  logic        halt_req = 1'b0;

  logic        cpu_en, running, halted;
  logic [3:0]  led_run;
  logic [15:0] cycle_count;

  logic        cpu_en4, running4, halted4;
  logic [3:0]  led_run4;
  logic [3:0]  cycle_count4;

  int compared = 0;
  int mismatched = 0;

`ifdef MIC1_EXEC_CYCLE_COUNT_EN
  localparam bit COUNT_EN = 1'b1;
`else
  localparam bit COUNT_EN = 1'b0;
`endif

  mic1_exec_ctrl #(.CNT_W(16), .LED_DIV_W(4)) dut (
    .clk(clk), .reset(reset), .start_stop_evt(start_stop_evt), .step_evt(step_evt),
    .cyc_done(cyc_done), .halt_req(halt_req), .cpu_en(cpu_en), .running(running),
    .halted(halted), .led_run(led_run), .cycle_count(cycle_count)
  );

  mic1_exec_ctrl #(.CNT_W(4), .LED_DIV_W(4)) dut4 (
    .clk(clk), .reset(reset), .start_stop_evt(start_stop_evt), .step_evt(step_evt),
    .cyc_done(cyc_done), .halt_req(halt_req), .cpu_en(cpu_en4), .running(running4),
    .halted(halted4), .led_run(led_run4), .cycle_count(cycle_count4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_cnt(input logic [31:0] v);
    return COUNT_EN ? v : 32'd0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive inputs, take one rising edge, and settle 1 ns past it for sampling.
  task automatic applyStimulus(input logic ss, input logic st, input logic cd, input logic hr);
    start_stop_evt = ss;
    step_evt       = st;
    cyc_done       = cd;
    halt_req       = hr;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0);
  endtask

  initial begin
    doReset();
    checkOutput("rst_cpu_en", cpu_en, 0);
    checkOutput("rst_running", running, 0);
    checkOutput("rst_halted", halted, 0);
    checkOutput("rst_led", led_run, 4'b0001);
    checkOutput("rst_count", cycle_count, 0);

    // Single step with cyc_done already high: one enabled cycle.
    applyStimulus(0, 1, 1, 0);
    checkOutput("step_en_on", cpu_en, 1);
    checkOutput("step_running", running, 0);
    checkOutput("step_cnt0", cycle_count, 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("step_en_off", cpu_en, 0);
    checkOutput("step_cnt1", cycle_count, exp_cnt(1));
    checkOutput("step_led", led_run, 4'b0001);
    applyStimulus(0, 0, 1, 0);
    checkOutput("step_idle_cnt", cycle_count, exp_cnt(1));

    // 40-retire run, with 4-bit counter wrap observed after 17.
    doReset();
    applyStimulus(1, 0, 1, 0);
    checkOutput("run_en", cpu_en, 1);
    checkOutput("run_cnt0", cycle_count, 0);
    for (int i = 0; i < 17; i++) applyStimulus(0, 0, 1, 0);
    checkOutput("wrap_cnt4", cycle_count4, exp_cnt(1));
    checkOutput("run_cnt17", cycle_count, exp_cnt(17));
    checkOutput("run_led17", led_run, 4'b0010);
    for (int i = 0; i < 23; i++) applyStimulus(0, 0, 1, 0);
    checkOutput("run_running", running, 1);
    checkOutput("run_cnt40", cycle_count, exp_cnt(40));
    checkOutput("run_led40", led_run, 4'b0100);

    // Stop without a retire: drain until the next completion.
    applyStimulus(1, 0, 0, 0);
    checkOutput("drain_en", cpu_en, 1);
    checkOutput("drain_running", running, 1);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("drain_hold_en", cpu_en, 1);
    checkOutput("drain_hold_cnt", cycle_count, exp_cnt(40));
    applyStimulus(0, 0, 1, 0);
    checkOutput("drain_done_en", cpu_en, 0);
    checkOutput("drain_done_run", running, 0);
    checkOutput("drain_cnt41", cycle_count, exp_cnt(41));
    checkOutput("drain_cnt4", cycle_count4, exp_cnt(9));
    applyStimulus(0, 0, 1, 0);
    checkOutput("idle_ignore_cnt", cycle_count, exp_cnt(41));

    // HALT retire coincident with start/stop: halt wins.
    applyStimulus(1, 0, 0, 0);
    checkOutput("halt_pre_run", running, 1);
    applyStimulus(1, 0, 1, 1);
    checkOutput("halt_halted", halted, 1);
    checkOutput("halt_en", cpu_en, 0);
    checkOutput("halt_running", running, 0);
    checkOutput("halt_led", led_run, 4'b1111);
    checkOutput("halt_cnt", cycle_count, exp_cnt(42));
    applyStimulus(0, 1, 1, 1);
    applyStimulus(0, 0, 1, 0);
    checkOutput("halt_stay", halted, 1);
    checkOutput("halt_ignore_cnt", cycle_count, exp_cnt(42));
    checkOutput("halt_stay_led", led_run, 4'b1111);
    applyStimulus(1, 0, 0, 0);
    checkOutput("unhalt_halted", halted, 0);
    checkOutput("unhalt_en", cpu_en, 0);
    checkOutput("unhalt_led", led_run, 4'b0001);

    // Start and step together from IDLE: start/stop wins.
    applyStimulus(1, 1, 0, 0);
    checkOutput("both_running", running, 1);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("both_cont_en", cpu_en, 1);
    checkOutput("both_cont_run", running, 1);
    // Stop coincident with a retire goes straight to IDLE.
    applyStimulus(1, 0, 1, 0);
    checkOutput("stop_ret_en", cpu_en, 0);
    checkOutput("stop_ret_run", running, 0);
    checkOutput("stop_ret_cnt", cycle_count, exp_cnt(43));
    checkOutput("stop_ret_led", led_run, 4'b0001);

    // Asynchronous reset in the middle of RUN.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("pre_arst_en", cpu_en, 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("arst_en", cpu_en, 0);
    checkOutput("arst_running", running, 0);
    checkOutput("arst_halted", halted, 0);
    checkOutput("arst_led", led_run, 4'b0001);
    checkOutput("arst_cnt", cycle_count, 0);
    checkOutput("arst_cnt4", cycle_count4, 0);
    applyStimulus(0, 0, 1, 0);
    reset = 1'b0;
    applyStimulus(0, 0, 1, 0);
    checkOutput("post_arst_en", cpu_en, 0);
    checkOutput("post_arst_cnt", cycle_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mic1_exec_ctrl.md
# mic1_exec_ctrl

Execution controller that sits downstream of the debounced front-panel button logic and drives the MIC-1 datapath's microinstruction enable. It turns single-cycle start/stop and step events into a run/step/halt state machine. It handshakes each microinstruction with the CPU via an enable/done pair, counts retired microinstructions, and drives the rotating run-indicator LEDs.

## Interface
- CNT_W, 16, width of the retired-microinstruction counter
- LED_DIV_W, 4, run LEDs advance once every 2^LED_DIV_W retirements
- clk  in  1  system clock; one clock
- reset  in  1  asynchronous, active-high reset
- start_stop_evt  in  1  one-cycle pulse: toggle run/stop
- step_evt  in  1  one-cycle pulse: execute one microinstruction
- cyc_done  in  1  CPU: current microinstruction completes this cycle
- halt_req  in  1  CPU: retiring microinstruction is a HALT (valid with cyc_done)
- cpu_en  out  1  enable/request to CPU datapath
- running  out  1  high in RUN or DRAIN
- halted  out  1  high in HALTED
- led_run  out  4  run indicator
- cycle_count  out  CNT_W  retired microinstructions

## Operation
- Retire = cpu_en & cyc_done sampled on a rising clk edge; exactly one microinstruction per retire.
- States: IDLE, RUN, STEP, DRAIN, HALTED; all outputs registered.
- IDLE: cpu_en=0. start_stop_evt -> RUN. step_evt -> STEP. Both same cycle -> RUN (start_stop wins).
- RUN: cpu_en=1 continuously. Retire with halt_req -> HALTED. start_stop_evt with no retire that cycle -> DRAIN. start_stop_evt coincident with a retire -> IDLE. step_evt ignored.
- DRAIN: cpu_en=1 until next retire, then IDLE (or HALTED if halt_req). Events ignored.
- STEP: cpu_en=1 until first retire, then IDLE (or HALTED if halt_req). Events ignored.
- HALTED: cpu_en=0. start_stop_evt -> IDLE. step_evt ignored.
- halt_req wins over any coincident start_stop_evt.
- cycle_count increments by 1 on every retire, modulo 2^CNT_W (wraps 2^CNT_W-1 -> 0). Never cleared except by reset.
- led_run: one-hot, rotates left (0001->0010->0100->1000->0001) after every 2^LED_DIV_W retires counted by an internal LED_DIV_W-bit prescaler.
  - Holds its value in IDLE/STEP.
  - Forced to 4'b1111 in HALTED.
  - Restored to 4'b0001 with prescaler cleared on the HALTED -> IDLE transition.

## Timing
- Reset values: state=IDLE, cpu_en=0, running=0, halted=0, led_run=4'b0001, cycle_count=0, prescaler=0.
- Reset is asynchronous and takes effect mid-operation. An in-flight microinstruction is abandoned and not counted.
- Event pulse on edge N -> cpu_en=1 after edge N (visible cycle N+1).
- STEP: cpu_en drops the cycle after the retiring edge. Minimum step = 1 enabled cycle when cyc_done is already high.
- DRAIN/RUN-to-IDLE: cpu_en drops after the retiring edge. No retire occurs after the IDLE transition.
- halted asserts and led_run=1111 in the cycle after the HALT retire edge.
- cycle_count and led_run update on the same edge as the retire.
- cyc_done/halt_req are ignored while cpu_en=0.

## Configuration
- MIC1_EXEC_CYCLE_COUNT_EN
  - Defined: the CNT_W retire counter is built and cycle_count behaves as above.
  - Undefined: the counter logic is removed and cycle_count is tied to 0.
  - Neither setting affects the FSM, cpu_en, or led_run, including the prescaler.

## Test plan
- Reset, then step_evt with cyc_done held 1 -> cpu_en high exactly 1 cycle, cycle_count=1, state back to IDLE, led_run=0001.
- start_stop_evt, cyc_done=1 for 40 cycles, LED_DIV_W=4 -> running=1, cycle_count=40, led_run=0100. Then start_stop_evt with cyc_done=0 -> DRAIN. cpu_en stays 1 until cyc_done pulse, then 0; cycle_count=41.
- RUN, retire with halt_req=1 and start_stop_evt in the same cycle -> halted=1, cpu_en=0, led_run=1111. Later start_stop_evt -> IDLE, led_run=0001.
- start_stop_evt and step_evt in the same cycle from IDLE -> RUN (running=1, continuous cpu_en).
- CNT_W=4: run 17 retires -> cycle_count=1 (wrap). Assert reset mid-RUN with cyc_done=0 -> all outputs at reset values immediately, with no clock edge needed.
- Build without MIC1_EXEC_CYCLE_COUNT_EN: repeat the 40-retire run -> cycle_count=0, led_run=0100.
